// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 2-read/1-write architectural register file with x0 hardwired to zero
module reg_file_2r1w #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    output logic             wr_done
);

    // Entry 0 exists only to keep indexing uniform; it is cleared by reset
    // and never written, and reads of address 0 are forced to zero anyway.
    logic [WIDTH-1:0] mem [NREGS];
    logic             wr_en;

    // A write is real only when it targets a non-zero register.
    assign wr_en = we && (waddr != '0);

    // Storage update: asynchronous clear, otherwise capture the write-back word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // One-cycle strobe following each accepted non-x0 write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_done <= 1'b0;
        end else begin
            wr_done <= wr_en;
        end
    end

    // Read port 1: zero during reset and for x0, forwarded write data when bypassing.
    always_comb begin
        rdata1 = '0;
        if (!rst && (raddr1 != '0)) begin
            if ((BYPASS != 0) && we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = mem[raddr1];
            end
        end
    end

    // Read port 2: same selection as port 1, driven by raddr2.
    always_comb begin
        rdata2 = '0;
        if (!rst && (raddr2 != '0)) begin
            if ((BYPASS != 0) && we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = mem[raddr2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - directed self-checking bench for reg_file_2r1w
module tb_reg_file_2r1w;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        wr_done;

    int errors = 0;
    int checks = 0;

    reg_file_2r1w #(
        .WIDTH  (32),
        .NREGS  (32),
        .AW     (5),
        .BYPASS (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr1  (raddr1),
        .raddr2  (raddr2),
        .rdata1  (rdata1),
        .rdata2  (rdata2),
        .wr_done (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a single write on the next rising edge, then drop we.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;

        // Reset state: every address on both ports reads zero.
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1;
            check($sformatf("rst_rd1_%0d", i), rdata1, 32'h0);
            check($sformatf("rst_rd2_%0d", 31 - i), rdata2, 32'h0);
        end
        check("rst_wr_done", {31'b0, wr_done}, 32'h0);

        @(negedge clk);
        rst = 1'b0;

        // Basic write/read with a one-cycle wr_done strobe.
        do_write(5'd5, 32'hDEADBEEF);
        raddr1 = 5'd5;
        #1;
        check("x5_read", rdata1, 32'hDEADBEEF);
        check("x5_wr_done_hi", {31'b0, wr_done}, 32'h1);
        @(negedge clk);
        #1;
        check("x5_wr_done_lo", {31'b0, wr_done}, 32'h0);

        // x0 protection, including during the write cycle with bypass.
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        check("x0_byp_rd1", rdata1, 32'h0);
        check("x0_byp_rd2", rdata2, 32'h0);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("x0_rd1", rdata1, 32'h0);
        check("x0_rd2", rdata2, 32'h0);
        check("x0_wr_done", {31'b0, wr_done}, 32'h0);

        // Bypass: old value without we, new value forwarded in the write cycle.
        do_write(5'd7, 32'h11111111);
        raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        check("x7_old_rd1", rdata1, 32'h11111111);
        check("x7_old_rd2", rdata2, 32'h11111111);
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'h22222222;
        #1;
        check("x7_byp_rd1", rdata1, 32'h22222222);
        check("x7_byp_rd2", rdata2, 32'h22222222);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("x7_new_rd1", rdata1, 32'h22222222);
        check("x7_new_rd2", rdata2, 32'h22222222);

        // Independent ports; writing x31 must not disturb reads of other registers.
        do_write(5'd1, 32'h00000001);
        @(negedge clk);
        we = 1'b1; waddr = 5'd31; wdata = 32'h80000000; raddr1 = 5'd1; raddr2 = 5'd5;
        #1;
        check("noint_rd1", rdata1, 32'h00000001);
        check("noint_rd2", rdata2, 32'hDEADBEEF);
        @(negedge clk);
        we = 1'b0; raddr1 = 5'd1; raddr2 = 5'd31;
        #1;
        check("ind_rd1", rdata1, 32'h00000001);
        check("ind_rd2", rdata2, 32'h80000000);
        raddr1 = 5'd31; raddr2 = 5'd1;
        #1;
        check("swap_rd1", rdata1, 32'h80000000);
        check("swap_rd2", rdata2, 32'h00000001);

        // Asynchronous reset pulse between edges clears state immediately.
        do_write(5'd3, 32'hA5A5A5A5);
        raddr1 = 5'd3; raddr2 = 5'd5;
        #1;
        check("x3_pre_rst", rdata1, 32'hA5A5A5A5);
        #1;
        rst = 1'b1;
        #1;
        check("x3_in_rst", rdata1, 32'h0);
        check("x5_in_rst", rdata2, 32'h0);
        check("rst_pulse_wr_done", {31'b0, wr_done}, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check("x3_after_rst", rdata1, 32'h0);
        check("x5_after_rst", rdata2, 32'h0);

        // A write whose edge sees rst high is lost; bypass is also blocked in reset.
        @(negedge clk);
        rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h12345678; raddr1 = 5'd3;
        #1;
        check("rst_byp_blocked", rdata1, 32'h0);
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        #1;
        check("rst_write_lost", rdata1, 32'h0);
        check("rst_write_wr_done", {31'b0, wr_done}, 32'h0);

        // Normal operation resumes after reset release.
        do_write(5'd3, 32'h0BADF00D);
        #1;
        check("post_rst_write", rdata1, 32'h0BADF00D);
        check("post_rst_wr_done", {31'b0, wr_done}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
